// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, combinational imem address, and a 2-entry
// {pc, inst} FIFO feeding decode over valid/ready; redirect flushes and reloads.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);
  localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t [1:0] ent;
  logic [31:0]  pc;
  logic [1:0]   count;
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop;
  logic         push;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_inst  = out_valid ? ent[rd_ptr].inst : 32'h0;
  assign out_pc    = out_valid ? ent[rd_ptr].pc   : 32'h0;

  assign pop  = out_valid & out_ready;
  assign push = !redirect_valid & ((count < 2'd2) | pop);
  // With count==2 the tail slot is the head slot, which frees up on the same-cycle pop.
  assign wr_ptr = rd_ptr ^ count[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00} & PC_MASK;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) pc <= (pc + 32'd4) & PC_MASK;
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push) ent[wr_ptr] <= '{pc: pc, inst: imem_data};
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a queue-based reference model of the fetch FIFO.
module tb_fetch_unit;
  localparam int          MEM_BYTES = 1024;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] MASK      = 32'(MEM_BYTES - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  logic [31:0] mem [MEM_BYTES/4];
  item_t       q[$];
  logic [31:0] mpc;
  int          errors = 0;
  int          checks = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:2]];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  // Advance one edge and update the reference model from the driven inputs.
  task automatic step();
    bit pop, push;
    @(posedge clk);
    pop  = (q.size() > 0) && out_ready;
    push = !redirect_valid && ((q.size() < 2) || pop);
    if (redirect_valid) begin
      q.delete();
      mpc = {redirect_pc[31:2], 2'b00} & MASK;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: mpc, inst: word_at(mpc)});
        mpc = (mpc + 32'd4) % MEM_BYTES;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    q.delete(); mpc = RESET_PC;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%h required=0", out_pc); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst actual=%h required=0", out_inst); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr actual=%h required=%h", imem_addr, RESET_PC); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid actual=%b required=0", out_valid); end
    @(negedge clk);
    rst = 1'b0; q.delete(); mpc = RESET_PC;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL stream_first actual=%b/%h required=1/0", out_valid, out_pc); end
    checks++; if (out_inst !== 32'h0010_0313) begin errors++; $display("FAIL stream_first_inst actual=%h required=00100313", out_inst); end
    step();
    checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL stream_second actual=%h required=4", out_pc); end
    checks++; if (out_inst !== 32'h0063_0333) begin errors++; $display("FAIL stream_second_inst actual=%h required=00630333", out_inst); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_hold_%0d actual=%b/%h required=1/0", i, out_valid, out_pc); end
    end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr actual=%h required=8", imem_addr); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin errors++; $display("FAIL bp_resume_%0d actual=%b/%h required=1/%h", k, out_valid, out_pc, 32'(4 * k)); end
      checks++; if (out_inst !== word_at(32'(4 * k))) begin errors++; $display("FAIL bp_inst_%0d actual=%h required=%h", k, out_inst, word_at(32'(4 * k))); end
      step();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble actual=%b required=0", out_valid); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL redir_addr actual=%h required=10", imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin errors++; $display("FAIL redir_target actual=%b/%h required=1/10", out_valid, out_pc); end
    checks++; if (out_inst !== word_at(32'h10)) begin errors++; $display("FAIL redir_inst actual=%h required=%h", out_inst, word_at(32'h10)); end
  endtask

  task automatic test_redirect_full_pop();
    apply_reset();
    out_ready = 1'b0;
    step(); step(); step();
    checks++; if (imem_addr !== 32'h8 || out_pc !== 32'h0) begin errors++; $display("FAIL full_setup actual=%h/%h required=8/0", imem_addr, out_pc); end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL full_flush actual=%b/%h required=0/40", out_valid, imem_addr); end
    step();
    checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL full_no_stale actual=%h required=40", out_pc); end
    step();
    checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL full_next actual=%h required=44", out_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h3FC; exp_pc[1] = 32'h0; exp_pc[2] = 32'h4;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h3FC) begin errors++; $display("FAIL wrap_redir actual=%b/%h required=0/3fc", out_valid, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k]) begin errors++; $display("FAIL wrap_seq_%0d actual=%b/%h required=1/%h", k, out_valid, out_pc, exp_pc[k]); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid actual=%b required=0", out_valid); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL mid_addr actual=%h required=%h", imem_addr, RESET_PC); end
    @(negedge clk);
    rst = 1'b0; q.delete(); mpc = RESET_PC; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin errors++; $display("FAIL mid_restart actual=%b/%h required=1/%h", out_valid, out_pc, RESET_PC); end
    step();
    checks++; if (out_pc !== RESET_PC + 32'd4) begin errors++; $display("FAIL mid_restart2 actual=%h required=%h", out_pc, RESET_PC + 32'd4); end
  endtask

  task automatic test_random();
    logic        ev;
    logic [31:0] epc, einst;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      ev    = (q.size() > 0);
      epc   = ev ? q[0].pc : 32'h0;
      einst = ev ? q[0].inst : 32'h0;
      checks++;
      if (out_valid !== ev || out_pc !== epc || out_inst !== einst || imem_addr !== mpc) begin
        errors++;
        $display("FAIL rand_%0d actual=%b/%h/%h/%h required=%b/%h/%h/%h", i,
                 out_valid, out_pc, out_inst, imem_addr, ev, epc, einst, mpc);
      end
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = (i % 50 == 7) ? 32'hFFFF_FFFE : $urandom();
      step();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES / 4; i++) mem[i] = $urandom();
    mem[0] = 32'h0010_0313;
    mem[1] = 32'h0063_0333;
    q.delete(); mpc = RESET_PC;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. Holds the program counter, drives the byte address of the combinational instruction memory (`inst_mem`) and captures each returned 32-bit word together with its PC into a 2-entry fetch FIFO. The FIFO feeds the decode stage over a valid/ready handshake. A redirect port, driven by branch/jump resolution, flushes the FIFO and reloads the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; low 2 bits must be 0.
- `MEM_BYTES`, default 1024: instruction memory size in bytes; power of two, at least 8. The PC wraps modulo `MEM_BYTES`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_addr` out 32: byte address to `inst_mem`; equals the `pc` register (combinational from the register).
- `imem_data` in 32: instruction word returned combinationally by `inst_mem` for `imem_addr`.
- `redirect_valid` in 1: load a new PC this cycle and flush the FIFO.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored (forced to 0).
- `out_valid` out 1: the FIFO head is valid.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_inst` out 32: instruction at the FIFO head; 0 when `out_valid`=0.
- `out_pc` out 32: PC of `out_inst`; 0 when `out_valid`=0.

## Operation
- State:
  - `pc` register (32 bits).
  - 2-entry FIFO of {pc, inst}, implemented as two entries plus a 2-bit `count` (0..2) and a 1-bit read pointer.
- Pop: `pop = out_valid & out_ready`.
- Push: `push = !redirect_valid & (count < 2 | pop)`.
  - A push writes {`pc`, `imem_data`} at the tail.
  - A push advances `pc <= (pc + 4) & (MEM_BYTES-1)`.
- When `count` is 2 and there is no pop, push is 0 and `pc` holds.
- Redirect (`redirect_valid`=1) takes priority over everything:
  - `count <= 0`.
  - `pc <= {redirect_pc[31:2], 2'b00} & (MEM_BYTES-1)`.
  - No push that cycle.
  - A simultaneous pop still counts as a completed transfer for decode, but the FIFO is cleared regardless.
- Push and pop in the same cycle: `count` is unchanged and FIFO order is preserved (the head entry leaves, the new entry goes to the tail).
- Wrap-around: a push at `pc` = `MEM_BYTES-4` sets the next `pc` to 0. No other address arithmetic exists.
- Upper PC bits above log2(`MEM_BYTES`) are always 0.
- `out_inst`/`out_pc` are muxed from the head entry when `count`>0, else 0.
- No halt or exception logic; the decode stage throttles fetch only via `out_ready`.

## Timing
- Reset (async assert, any time):
  - `pc` = `RESET_PC` and `count` = 0, immediately.
  - Outputs: `out_valid`=0, `out_inst`=0, `out_pc`=0, `imem_addr`=`RESET_PC`.
  - Reset mid-operation discards all FIFO contents.
- First edge after reset deasserts: the word at `RESET_PC` is pushed; `out_valid`=1 from that cycle on.
- Fetch-to-output latency: 1 cycle. A word present on `imem_data` at edge N appears on `out_inst` after edge N when the FIFO was empty.
- Sustained throughput with `out_ready`=1: one instruction per cycle, consecutive PCs.
- Backpressure with `out_ready`=0:
  - FIFO fills to 2 entries in two edges; `pc` then holds at (head PC + 8).
  - When `out_ready` rises, streaming resumes with no bubble and no lost or duplicated PC.
- Redirect at edge N:
  - `out_valid`=0 for the cycle after N.
  - The target word is pushed at edge N+1 and is valid after N+1 (1 bubble).
- Back-to-back redirects: each one flushes; only the last target is fetched.
- Handshake rules:
  - `out_inst`/`out_pc` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` drops only on a pop that empties the FIFO or on a redirect.

## Test plan
- Reset then stream: `inst_mem` word at 0 = 32'h0010_0313 and at 4 = 32'h0063_0333, `out_ready`=1. Required:
  - `out_valid`=0 during reset.
  - After the first edge: `out_pc`=0, `out_inst`=32'h0010_0313.
  - Next cycle: `out_pc`=4, `out_inst`=32'h0063_0333.
- Backpressure: hold `out_ready`=0 for 5 cycles after reset. Required:
  - `count` reaches 2; `imem_addr` sticks at 8; `out_pc` stays 0.
  - Raise `out_ready`: `out_pc` sequence 0,4,8,12 with no gaps.
- Redirect: while streaming, assert `redirect_valid` with `redirect_pc`=32'h0000_0013. Required:
  - Next cycle `out_valid`=0 and `imem_addr`=32'h10.
  - Following cycle `out_pc`=32'h10.
- Redirect with full FIFO and simultaneous pop: `count`=2, `out_ready`=1, `redirect_valid`=1 to 32'h40. Required: the FIFO is empty the next cycle; the old second entry is never presented.
- Wrap-around: `MEM_BYTES`=1024, redirect to 32'h3FC, `out_ready`=1. Required: `out_pc` sequence 32'h3FC, 0, 4.
- Reset mid-operation: assert `rst` asynchronously between edges with `count`=2. Required:
  - `out_valid`=0 and `imem_addr`=`RESET_PC` before the next edge.
  - Stream restarts at `RESET_PC` after release.
